// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/FETCH/HOLD control, and the IF/ID pipeline register.
// Optional bubble counter port perf_bubble_cnt is enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_bubble_cnt,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic [15:0] ifid_imm
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        valid_next;
    logic [31:0] instr_next;
    logic [31:0] pc4_next;
    logic        bubble;

    // Redirect beats stall, which beats a returning instruction; BOOT ignores both.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        valid_next = ifid_valid;
        instr_next = ifid_instr;
        pc4_next   = ifid_pc4;
        bubble     = 1'b0;

        case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH, HOLD: begin
                if (redirect) begin
                    pc_next    = redirect_pc & ALIGN_MASK;
                    valid_next = 1'b0;
                    instr_next = 32'h0;
                    state_next = FETCH;
                end else if (stall) begin
                    state_next = HOLD;
                end else if (state == HOLD) begin
                    // No request was issued while holding, so nothing can be captured here.
                    state_next = FETCH;
                end else if (imem_ready) begin
                    instr_next = imem_rdata;
                    pc4_next   = pc + 32'd4;
                    valid_next = 1'b1;
                    pc_next    = pc + 32'd4;
                end else begin
                    valid_next = 1'b0;
                    instr_next = 32'h0;
                    bubble     = 1'b1;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC_ALIGNED;
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
            ifid_pc4   <= 32'h0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ifid_valid <= valid_next;
            ifid_instr <= instr_next;
            ifid_pc4   <= pc4_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating count of memory-not-ready bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubble_cnt <= 32'h0;
        end else if (bubble && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`else
    logic unused_bubble;
    assign unused_bubble = bubble;
`endif

    assign imem_req  = (state == FETCH) && !stall && !redirect;
    assign imem_addr = pc & ALIGN_MASK;
    assign ifid_imm  = ifid_instr[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a rule-level model.
// Checks perf_bubble_cnt as well when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_w = 1'b1;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        imem_req, w_req;
    logic [31:0] imem_addr, w_addr;
    logic        ifid_valid, w_valid;
    logic [31:0] ifid_instr, w_instr;
    logic [31:0] ifid_pc4, w_pc4;
    logic [15:0] ifid_imm, w_imm;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt, w_perf;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: where the fetch stage should be, in terms of the rules it obeys.
    bit          m_booting;
    bit          m_holding;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    longint      m_bubbles;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
`ifdef FETCH_PERF_CNT_EN
        .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc4(ifid_pc4), .ifid_imm(ifid_imm)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst_w),
`ifdef FETCH_PERF_CNT_EN
        .perf_bubble_cnt(w_perf),
`endif
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .ifid_valid(w_valid), .ifid_instr(w_instr),
        .ifid_pc4(w_pc4), .ifid_imm(w_imm)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_booting = 1'b1;
        m_holding = 1'b0;
        m_pc      = 32'h0;
        m_valid   = 1'b0;
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_bubbles = 0;
    endtask

    // Advance one rising edge, let the model apply the same edge, then settle 1 time unit.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (redirect) begin
            m_pc      = {redirect_pc[31:2], 2'b00};
            m_valid   = 1'b0;
            m_instr   = 32'h0;
            m_holding = 1'b0;
        end else if (stall) begin
            m_holding = 1'b1;
        end else if (m_holding) begin
            m_holding = 1'b0;
        end else if (imem_ready) begin
            m_instr = imem_rdata;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end else begin
            m_valid = 1'b0;
            m_instr = 32'h0;
            if (m_bubbles < 64'h0000_0000_FFFF_FFFF) m_bubbles++;
        end
        #1;
    endtask

    function automatic bit exp_req();
        return !rst && !m_booting && !m_holding && !stall && !redirect;
    endfunction

    task automatic test_reset();
        rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
        #3;
        model_reset();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b, want 0", imem_req); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, want 0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h, want 0", ifid_instr); end
        checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc4: got %h, want 0", ifid_pc4); end
        checks++; if (ifid_imm !== 16'h0) begin errors++; $display("[TB] FAIL reset_imm: got %h, want 0", ifid_imm); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h, want 0", imem_addr); end
        tick();
        rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h2008_0001;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL boot_req: got %b, want 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_fetch_req: got %b, want 1", imem_req); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL first_fetch_valid: got %b, want 0", ifid_valid); end
        tick();
        checks++; if (ifid_instr !== 32'h2008_0001) begin errors++; $display("[TB] FAIL first_instr: got %h, want 20080001", ifid_instr); end
        checks++; if (ifid_pc4 !== 32'd4) begin errors++; $display("[TB] FAIL first_pc4: got %h, want 4", ifid_pc4); end
        checks++; if (ifid_imm !== 16'h0001) begin errors++; $display("[TB] FAIL first_imm: got %h, want 0001", ifid_imm); end
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %b, want 1", ifid_valid); end
        checks++; if (imem_addr !== 32'd4) begin errors++; $display("[TB] FAIL first_next_addr: got %h, want 4", imem_addr); end
    endtask

    task automatic test_bubble();
        imem_rdata = $urandom;
        tick();
        checks++; if (imem_addr !== 32'd8) begin errors++; $display("[TB] FAIL bubble_start_addr: got %h, want 8", imem_addr); end
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL bubble_valid[%0d]: got %b, want 0", i, ifid_valid); end
            checks++; if (ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL bubble_instr[%0d]: got %h, want 0", i, ifid_instr); end
            checks++; if (imem_addr !== 32'd8) begin errors++; $display("[TB] FAIL bubble_addr[%0d]: got %h, want 8", i, imem_addr); end
        end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_bubble_cnt !== 32'd2) begin errors++; $display("[TB] FAIL bubble_count: got %0d, want 2", perf_bubble_cnt); end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] held;
        imem_ready = 1'b1; imem_rdata = $urandom;
        held = imem_rdata;
        tick();
        checks++; if (imem_addr !== 32'd12) begin errors++; $display("[TB] FAIL stall_start_addr: got %h, want c", imem_addr); end
        stall = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_comb: got %b, want 0", imem_req); end
        for (int i = 0; i < 3; i++) begin
            imem_rdata = $urandom;
            tick();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req[%0d]: got %b, want 0", i, imem_req); end
            checks++; if (imem_addr !== 32'd12) begin errors++; $display("[TB] FAIL stall_addr[%0d]: got %h, want c", i, imem_addr); end
            checks++; if (ifid_instr !== held) begin errors++; $display("[TB] FAIL stall_instr[%0d]: got %h, want %h", i, ifid_instr, held); end
            checks++; if (ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %b, want 1", i, ifid_valid); end
            checks++; if (ifid_pc4 !== 32'd12) begin errors++; $display("[TB] FAIL stall_pc4[%0d]: got %h, want c", i, ifid_pc4); end
        end
        stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_req: got %b, want 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL release_req: got %b, want 1", imem_req); end
        checks++; if (imem_addr !== 32'd12) begin errors++; $display("[TB] FAIL release_addr: got %h, want c", imem_addr); end
        checks++; if (ifid_instr !== held) begin errors++; $display("[TB] FAIL hold_ignores_ready: got %h, want %h", ifid_instr, held); end
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (ifid_instr !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL release_instr: got %h, want deadbeef", ifid_instr); end
        checks++; if (ifid_pc4 !== 32'd16) begin errors++; $display("[TB] FAIL release_pc4: got %h, want 10", ifid_pc4); end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h0000_0043; stall = 1'b1; imem_ready = 1'b1;
        imem_rdata = $urandom;
        tick();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL redirect_valid: got %b, want 0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL redirect_instr: got %h, want 0", ifid_instr); end
        checks++; if (imem_addr !== 32'h0000_0040) begin errors++; $display("[TB] FAIL redirect_addr: got %h, want 40", imem_addr); end
        redirect = 1'b0; stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL redirect_req: got %b, want 1", imem_req); end
        tick();
        checks++; if (ifid_pc4 !== 32'h0000_0044) begin errors++; $display("[TB] FAIL redirect_pc4: got %h, want 44", ifid_pc4); end
    endtask

    task automatic test_mid_reset();
        imem_ready = 1'b1; imem_rdata = $urandom;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b, want 0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_instr: got %h, want 0", ifid_instr); end
        checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_pc4: got %h, want 0", ifid_pc4); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_addr: got %h, want 0", imem_addr); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_req: got %b, want 0", imem_req); end
        tick();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_drop: got %b, want 0", ifid_valid); end
    endtask

    task automatic test_random();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            imem_ready  = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 7) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            imem_rdata  = $urandom;
            tick();
            checks++;
            if (imem_req !== exp_req() || imem_addr !== m_pc || ifid_valid !== m_valid ||
                ifid_instr !== m_instr || ifid_pc4 !== m_pc4 || ifid_imm !== m_instr[15:0]) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got req=%b addr=%h v=%b instr=%h pc4=%h imm=%h, want req=%b addr=%h v=%b instr=%h pc4=%h imm=%h",
                         i, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc4, ifid_imm,
                         exp_req(), m_pc, m_valid, m_instr, m_pc4, m_instr[15:0]);
            end
`ifdef FETCH_PERF_CNT_EN
            checks++;
            if (perf_bubble_cnt !== m_bubbles[31:0]) begin
                errors++;
                $display("[TB] FAIL random_count[%0d]: got %0d, want %0d", i, perf_bubble_cnt, m_bubbles);
            end
`endif
        end
        stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_wrap();
        stall = 1'b0; redirect = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1234_ABCD;
        #1;
        checks++; if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_reset_addr: got %h, want fffffffc", w_addr); end
        rst_w = 1'b0;
        tick();
        checks++; if (w_req !== 1'b1) begin errors++; $display("[TB] FAIL wrap_req: got %b, want 1", w_req); end
        checks++; if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_fetch_addr: got %h, want fffffffc", w_addr); end
        tick();
        checks++; if (w_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid: got %b, want 1", w_valid); end
        checks++; if (w_instr !== 32'h1234_ABCD) begin errors++; $display("[TB] FAIL wrap_instr: got %h, want 1234abcd", w_instr); end
        checks++; if (w_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4: got %h, want 0", w_pc4); end
        checks++; if (w_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next_addr: got %h, want 0", w_addr); end
        #2;
        rst_w = 1'b1;
        #1;
        checks++; if (w_valid !== 1'b0 || w_instr !== 32'h0 || w_pc4 !== 32'h0 || w_imm !== 16'h0 || w_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_async_rst: got v=%b instr=%h pc4=%h imm=%h req=%b, want all 0", w_valid, w_instr, w_pc4, w_imm, w_req);
        end
        checks++; if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_rst_addr: got %h, want fffffffc", w_addr); end
        tick();
        checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_rst_drop: got %b, want 0", w_valid); end
    endtask

    initial begin
        $display("[TB] fetch_stage bench starting");
        test_reset();
        test_bubble();
        test_stall();
        test_redirect();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
